// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths and types for the pipelined left shifter
package shift_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  shamt_t;
endpackage

// File: rtl/lshift_stage.sv
// rtl/lshift_stage.sv - one registered stage of the left shifter
//
// Shifts by DIST when the matching shamt bit is set.
// Optional macro: LSHIFT_OVF_EN adds a sticky shifted-out flag (up_ovf/ovf).
// Ports:
//   clock, reset_n       clock, async active-low reset
//   up_valid/up_data/up_shamt  upstream stage contents
//   ready                this stage can load this cycle
//   valid/data/shamt     registered stage contents
//   dn_ready             downstream stage can load
module lshift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int DIST  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             up_valid,
    output logic             ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_shamt,
`ifdef LSHIFT_OVF_EN
    input  logic             up_ovf,
    output logic             ovf,
`endif
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shamt,
    input  logic             dn_ready
);
    localparam int BIT = $clog2(DIST);

    logic take;

    // An empty stage always loads, so bubbles collapse under a stall.
    assign ready = !valid || dn_ready;
    assign take  = up_shamt[BIT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data  <= take ? (up_data << DIST) : up_data;
                shamt <= up_shamt;
            end
        end
    end

`ifdef LSHIFT_OVF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (ready && up_valid) begin
            ovf <= up_ovf | (take & (|up_data[WIDTH-1 -: DIST]));
        end
    end
`endif
endmodule

// File: rtl/pipelined_leftshift.sv
// rtl/pipelined_leftshift.sv - 5-stage pipelined logical left barrel shifter
//
// Stage k shifts by 2^(SHW-1-k); valid/ready handshake on both sides.
// Optional macro: LSHIFT_OVF_EN drives overflow with the OR of shifted-out bits,
// otherwise overflow is tied to 0.
// Ports:
//   clock, reset_n        clock, async active-low reset
//   in_valid, in_ready    input handshake
//   operand, shamt        value and shift distance
//   out_valid, out_ready  output handshake
//   result, overflow      operand << shamt and shifted-out flag
//   busy                  any stage holds an operation
module pipelined_leftshift
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);
    // Index 0 is the pipeline input, index k+1 is the output of stage k.
    logic [SHW:0]     valid_p;
    logic [SHW:0]     ready_p;
    logic [WIDTH-1:0] data_p  [SHW+1];
    logic [SHW-1:0]   shamt_p [SHW+1];
    logic             unused_shamt;

    assign valid_p[0]   = in_valid;
    assign data_p[0]    = operand;
    assign shamt_p[0]   = shamt;
    assign ready_p[SHW] = out_ready;

`ifdef LSHIFT_OVF_EN
    logic [SHW:0] ovf_p;
    assign ovf_p[0] = 1'b0;
`endif

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        lshift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .DIST  (1 << (SHW - 1 - k))
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .up_valid (valid_p[k]),
            .ready    (ready_p[k]),
            .up_data  (data_p[k]),
            .up_shamt (shamt_p[k]),
`ifdef LSHIFT_OVF_EN
            .up_ovf   (ovf_p[k]),
            .ovf      (ovf_p[k+1]),
`endif
            .valid    (valid_p[k+1]),
            .data     (data_p[k+1]),
            .shamt    (shamt_p[k+1]),
            .dn_ready (ready_p[k+1])
        );
    end

    assign in_ready  = ready_p[0];
    assign out_valid = valid_p[SHW];
    assign result    = data_p[SHW];
    assign busy      = |valid_p[SHW:1];

`ifdef LSHIFT_OVF_EN
    assign overflow = ovf_p[SHW];
`else
    assign overflow = 1'b0;
`endif

    // Every shamt bit has been consumed by the last stage.
    assign unused_shamt = ^shamt_p[SHW];
endmodule

// File: doc/pipelined_leftshift.md
Name: pipelined_leftshift

Overview:
- Pipelined 32-bit logical left barrel shifter (SLL path), the opposite-direction partner of the combinational right shifter in the ALU.
- Computes one shift-amount bit per registered stage: 16, 8, 4, 2, then 1.
- Uses a valid/ready handshake on both sides, so the execute stage can stall it.
- Throughput is one operation per cycle; latency is 5 cycles.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two.
- SHW, $clog2(WIDTH) = 5, shift-amount width and number of pipeline stages.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/shamt valid
- in_ready  out  1  block can accept this cycle
- operand  in  WIDTH  value to shift
- shamt  in  SHW  shift distance, 0..WIDTH-1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operand << shamt, zero-filled
- overflow  out  1  nonzero bits shifted out (see Optional Feature)
- busy  out  1  OR of all stage valid bits

Behaviour:
- Stage k (k = 0..SHW-1) handles distance 2^(SHW-1-k). Stage 0 shifts by 16.
- Each stage registers: valid_k, data_k, the remaining shamt bits, and ovf_k.
- Stage k loads when ready_k = !valid_k | ready_(k+1).
  - ready for the last stage is out_ready.
  - in_ready = ready_0.
- On load: data_k = shamt_bit ? data_(k-1) << 2^(SHW-1-k) : data_(k-1). Vacated LSBs are 0.
- Valid propagation:
  - valid_k <= valid_(k-1) when ready_k, otherwise hold.
  - A stage whose upstream is empty becomes invalid once it hands off.
- Handshake:
  - A transfer happens on a cycle with in_valid & in_ready (input side) or out_valid & out_ready (output side).
  - out_valid = valid of the last stage; result = data of the last stage.
  - result and overflow hold stable while out_valid & !out_ready.
- Latency: input accepted at edge N gives out_valid at edge N+5 when the pipeline is not stalled.
- Back-pressure:
  - A full pipeline with out_ready = 0 holds all 5 entries and drives in_ready = 0.
  - Bubbles collapse: an empty stage loads even if downstream is stalled.
- Simultaneous accept and drain on a full pipeline: allowed, throughput stays at 1/cycle.
- shamt = 0: result = operand, overflow = 0.
- shamt = 31: result = {operand[0], 31'b0}.
- Reset (asynchronous, any time including mid-operation):
  - All valid bits clear, in-flight operations are discarded.
  - All data, shamt and ovf registers go to 0.
  - Outputs after reset: out_valid=0, result=0, overflow=0, busy=0, in_ready=1.
- There is no FSM beyond the per-stage valid bits. The design is fully synchronous apart from reset.

Optional Feature:
- Macro: LSHIFT_OVF_EN.
- Defined:
  - When a stage applies its shift, it ORs the shifted-out bits (the top 2^(SHW-1-k) bits of its input) into ovf_k.
  - overflow = ovf of the last stage, aligned with result.
- Undefined:
  - The overflow port remains and is tied to 0.
  - No ovf registers or OR logic are synthesised.

Decomposition:
- Package shift_pkg holds:
  - WIDTH_DEF=32 and SHW_DEF=5
  - typedef word_t = logic [31:0]
  - typedef shamt_t = logic [4:0]
- One sub-module, lshift_stage, parameterised by DIST:
  - One registered stage containing the valid, data, shamt and ovf regs plus the ready equation.
  - It is instantiated SHW times in a generate loop.

Test Plan:
- Reset then single op: operand=0x0000_0001, shamt=31, out_ready=1 -> out_valid 5 cycles after accept, result=0x8000_0000, overflow=0.
- Back-to-back ops, no stall: (0x1234_5678,4), (0xFFFF_FFFF,16), (0xA5A5_A5A5,0) on consecutive cycles -> results 0x2345_6780, 0xFFFF_0000, 0xA5A5_A5A5 on 3 consecutive cycles. With LSHIFT_OVF_EN, overflow is 1, 1, 0.
- Stall: send 7 ops with out_ready=0 -> in_ready drops after 5 accepts and busy=1. Raise out_ready -> all 7 results emerge in order with no loss or duplication, and result stays stable while stalled.
- Bubble collapse: one op, then idle for 3 cycles with out_ready=0, then a second op -> both ops are held in the last two stages without in_ready deasserting.
- Reset mid-flight: 3 ops in flight, assert reset_n=0 for 1 cycle -> out_valid=0, busy=0, result=0 immediately. None of the 3 ops is ever output.
- Random compare (5k ops, random in_valid/out_ready) -> every result equals (operand<<shamt) mod 2^32, and overflow equals |(operand >> (32-shamt)) for shamt>0.
